spi_burst_arbiter: RTL and testbench
====================================

Name: spi_burst_arbiter

Overview:
- Shares one spi_master (Mode 0, 8-bit frames) among NUM_REQ clients using round-robin arbitration.
- Each grant is a multi-byte burst. The block drives a per-client chip select (cs_n) and holds it low for the whole burst.
- spi_master's own ss_n is left unconnected at top level, because it toggles per byte.
- The block sequences the byte handshakes, CS setup/hold and inter-byte gaps, and returns RX bytes to the granted client.

Parameters:
- NUM_REQ, 4, number of requesting clients (2..8).
- LEN_W, 4, width of burst length field; burst = req_len+1 bytes (1..16).
- CS_SETUP_CYC, 2, clk cycles from cs_n low to first m_start.
- CS_HOLD_CYC, 2, clk cycles from last m_done to cs_n high.
- GAP_CYC, 1, idle clk cycles between m_done and next byte's tx_ready (0 allowed).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-client burst request, level
- req_len  in  NUM_REQ*LEN_W  per-client length, byte count minus 1; sampled at grant
- grant  out  NUM_REQ  one-hot, current owner
- tx_valid  in  NUM_REQ  per-client TX byte valid
- tx_data  in  NUM_REQ*8  per-client TX byte
- tx_ready  out  NUM_REQ  one-hot, granted client may present byte
- rx_valid  out  NUM_REQ  one-hot 1-cycle pulse, rx_data valid
- rx_data  out  8  received byte (shared bus)
- burst_done  out  NUM_REQ  one-hot 1-cycle pulse at burst end
- cs_n  out  NUM_REQ  per-client active-low chip select
- m_start  out  1  1-cycle start pulse to spi_master
- m_tx_data  out  8  byte to spi_master, held stable from m_start to m_done
- m_rx_data  in  8  spi_master rx_data
- m_busy  in  1  spi_master busy
- m_done  in  1  spi_master done pulse

Behaviour:
- Reset (sync, rst=1): state IDLE; grant=0, tx_ready=0, rx_valid=0, rx_data=0, burst_done=0, cs_n=all 1, m_start=0, m_tx_data=0, rr pointer=NUM_REQ-1 (so client 0 wins first). All outputs are registered.
- Reset mid-burst: cs_n releases on the next edge. The top level drives spi_master rst_n = ~rst, so the master aborts too. No burst_done is issued.
- FSM states: IDLE, CS_SETUP, WAIT_TX, START, WAIT_DONE, GAP, CS_HOLD.
- IDLE:
  - If any req is high, select the winner by round-robin starting at ptr+1 (wrapping).
  - Set grant, latch req_len into byte counter, set ptr=winner, drive cs_n[winner]=0, go to CS_SETUP.
  - Grant is registered, so it appears 1 cycle after req is seen.
- CS_SETUP: count CS_SETUP_CYC cycles, then go to WAIT_TX.
- WAIT_TX:
  - tx_ready[g]=1 only in this state and only while m_busy=0.
  - On tx_valid[g]&tx_ready[g]: capture tx_data[g] into m_tx_data, drop tx_ready, go to START.
  - There is no timeout; the block waits indefinitely.
- START: m_start=1 for exactly 1 cycle, then go to WAIT_DONE.
- WAIT_DONE:
  - On m_done: rx_data<=m_rx_data and rx_valid[g]=1 on the next cycle (1-cycle pulse).
  - If the byte counter is 0, go to CS_HOLD. Otherwise decrement and go to GAP (or directly to WAIT_TX if GAP_CYC=0).
- GAP: count GAP_CYC cycles, then go to WAIT_TX.
- CS_HOLD:
  - Count CS_HOLD_CYC cycles.
  - On exit: cs_n[g]=1, grant=0, burst_done[g]=1 pulse, go to IDLE.
  - New arbitration earliest the cycle after IDLE is re-entered (at least 1 cycle with all cs_n high).
- Request rules:
  - Deasserting req mid-burst is ignored; the burst runs to length.
  - A req held high after burst_done re-requests, but RR ptr gives other pending clients priority.
- Simultaneous req from several clients: exactly one is granted, and grant is always one-hot or zero.
- An m_done arriving outside WAIT_DONE is ignored. req_len changes after grant are ignored.
- Counters: setup/hold/gap counters are sized $clog2(max+1). The byte counter is LEN_W bits and decrements to 0 with no wrap.

Decomposition:
- Shared package spi_ctrl_pkg:
  - burst_state_t enum (7 states above).
  - SPI_BYTE_W=8 constant.
  - Helper function onehot_to_idx.
- One sub-module, spi_rr_arbiter: a combinational round-robin pick from req and ptr. It outputs a one-hot winner and a valid flag. The pointer register lives in the parent.

Test Plan:
- Single client 0, req_len=0, tx 0xA5, slave echoes 0x3C -> cs_n[0] low ≥2 cycles before m_start; exactly one m_start with m_tx_data=0xA5; rx_valid[0] with rx_data=0x3C; burst_done[0]; cs_n[0] high 2 cycles after m_done.
- Client 1 burst req_len=3, tx 0x01..0x04 -> 4 m_start pulses in order 0x01,0x02,0x03,0x04; cs_n[1] stays low throughout; 4 rx_valid[1] pulses; ≥GAP_CYC cycles between each m_done and the next tx_ready.
- All 4 clients request simultaneously from reset, each req_len=0, held high -> grant order 0,1,2,3,0; never two cs_n low at once.
- Client 2 holds tx_valid low for 50 cycles mid-burst -> tx_ready[2] stays high, no m_start, cs_n[2] stays low; the burst resumes when valid rises.
- rst pulsed during WAIT_DONE of a 3-byte burst -> next cycle all cs_n=1, grant=0, no burst_done; a new req afterwards is granted to client 0 priority.
- req[3] dropped after grant with req_len=1 -> 2 bytes still transferred, burst_done[3] pulses once.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI burst arbiter.
//   burst_state_t  : burst sequencer states
//   SPI_BYTE_W     : SPI frame width in bits
//   MAX_REQ        : largest supported client count (sizes onehot_to_idx)
//   onehot_to_idx  : index of the set bit of a one-hot vector (0 when empty)
package spi_ctrl_pkg;

    localparam int SPI_BYTE_W = 8;
    localparam int MAX_REQ    = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_WAIT_TX,
        S_START,
        S_WAIT_DONE,
        S_GAP,
        S_CS_HOLD
    } burst_state_t;

    // OR-reduction of the indices of all set bits; exact for one-hot input.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/spi_burst_arbiter_if.sv
// Bundle of client-side and spi_master-side signals of the burst arbiter.
//   master modport : the arbiter (drives grant/handshake/CS and the master's start)
//   slave  modport : clients plus the spi_master (drive requests, TX bytes, RX/status)
interface spi_burst_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 4
);
    import spi_ctrl_pkg::*;

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*LEN_W-1:0]      req_len;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            tx_valid;
    logic [NUM_REQ*SPI_BYTE_W-1:0] tx_data;
    logic [NUM_REQ-1:0]            tx_ready;
    logic [NUM_REQ-1:0]            rx_valid;
    logic [SPI_BYTE_W-1:0]         rx_data;
    logic [NUM_REQ-1:0]            burst_done;
    logic [NUM_REQ-1:0]            cs_n;
    logic                          m_start;
    logic [SPI_BYTE_W-1:0]         m_tx_data;
    logic [SPI_BYTE_W-1:0]         m_rx_data;
    logic                          m_busy;
    logic                          m_done;

    modport master (
        input  req, req_len, tx_valid, tx_data, m_rx_data, m_busy, m_done,
        output grant, tx_ready, rx_valid, rx_data, burst_done, cs_n, m_start, m_tx_data
    );

    modport slave (
        output req, req_len, tx_valid, tx_data, m_rx_data, m_busy, m_done,
        input  grant, tx_ready, rx_valid, rx_data, burst_done, cs_n, m_start, m_tx_data
    );

endinterface

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick. Search starts at ptr_i+1 and wraps, so the
// client at ptr_i (the previous owner) has the lowest priority.
//   req_i    : request vector
//   ptr_i    : index of the previous winner
//   winner_o : one-hot winner (zero when no request)
//   valid_o  : at least one request present
module spi_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] winner_o,
    output logic               valid_o
);

    logic [IDX_W-1:0] idx;

    // Walk from lowest to highest priority; the last hit overwrites earlier ones.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            if (req_i[idx]) begin
                winner_o      = '0;
                winner_o[idx] = 1'b1;
                valid_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_burst_arbiter.sv
// Shares one Mode-0 8-bit spi_master among NUM_REQ clients. Each grant is a
// burst of req_len+1 bytes with the client's cs_n held low throughout; the
// master's own ss_n is not used because it toggles per byte.
//   clk, rst : clock, synchronous active-high reset
//   bus      : client handshake (req/req_len/grant/tx_*/rx_*/burst_done/cs_n)
//              and spi_master handshake (m_start/m_tx_data/m_rx_data/m_busy/m_done)
module spi_burst_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int LEN_W        = 4,
    parameter int CS_SETUP_CYC = 2,
    parameter int CS_HOLD_CYC  = 2,
    parameter int GAP_CYC      = 1
) (
    input  logic                clk,
    input  logic                rst,
    spi_burst_arbiter_if.master bus
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX0 = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
    localparam int CNT_MAX1 = (CNT_MAX0 > GAP_CYC) ? CNT_MAX0 : GAP_CYC;
    localparam int CNT_MAX  = (CNT_MAX1 > 1) ? CNT_MAX1 : 1;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    burst_state_t          state_q;
    logic [NUM_REQ-1:0]    grant_q;
    logic [IDX_W-1:0]      ptr_q;
    logic [LEN_W-1:0]      byte_cnt_q;
    logic [CNT_W-1:0]      cyc_cnt_q;
    logic [NUM_REQ-1:0]    tx_ready_q;
    logic [NUM_REQ-1:0]    rx_valid_q;
    logic [SPI_BYTE_W-1:0] rx_data_q;
    logic [NUM_REQ-1:0]    burst_done_q;
    logic [NUM_REQ-1:0]    cs_n_q;
    logic                  m_start_q;
    logic [SPI_BYTE_W-1:0] m_tx_data_q;

    logic [SPI_BYTE_W-1:0] tx_bytes [NUM_REQ];
    logic [LEN_W-1:0]      len_arr  [NUM_REQ];
    logic [NUM_REQ-1:0]    arb_winner;
    logic                  arb_valid;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      g_idx;
    logic [NUM_REQ-1:0]    ready_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign tx_bytes[gi] = bus.tx_data[gi*SPI_BYTE_W +: SPI_BYTE_W];
            assign len_arr[gi]  = bus.req_len[gi*LEN_W +: LEN_W];
        end
    endgenerate

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .winner_o (arb_winner),
        .valid_o  (arb_valid)
    );

    assign w_idx = IDX_W'(onehot_to_idx(MAX_REQ'(arb_winner)));
    assign g_idx = IDX_W'(onehot_to_idx(MAX_REQ'(grant_q)));

    // tx_ready is only offered while the master is idle.
    assign ready_d = bus.m_busy ? '0 : grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            ptr_q        <= IDX_W'(NUM_REQ - 1);
            byte_cnt_q   <= '0;
            cyc_cnt_q    <= '0;
            tx_ready_q   <= '0;
            rx_valid_q   <= '0;
            rx_data_q    <= '0;
            burst_done_q <= '0;
            cs_n_q       <= '1;
            m_start_q    <= 1'b0;
            m_tx_data_q  <= '0;
        end else begin
            rx_valid_q   <= '0;
            burst_done_q <= '0;
            m_start_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (arb_valid) begin
                        grant_q    <= arb_winner;
                        cs_n_q     <= ~arb_winner;
                        ptr_q      <= w_idx;
                        byte_cnt_q <= len_arr[w_idx];
                        cyc_cnt_q  <= '0;
                        if (CS_SETUP_CYC == 0) begin
                            tx_ready_q <= bus.m_busy ? '0 : arb_winner;
                            state_q    <= S_WAIT_TX;
                        end else begin
                            state_q <= S_CS_SETUP;
                        end
                    end
                end
                S_CS_SETUP: begin
                    if (cyc_cnt_q == CNT_W'(CS_SETUP_CYC - 1)) begin
                        tx_ready_q <= ready_d;
                        state_q    <= S_WAIT_TX;
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 1'b1;
                    end
                end
                S_WAIT_TX: begin
                    if (|(bus.tx_valid & tx_ready_q)) begin
                        m_tx_data_q <= tx_bytes[g_idx];
                        tx_ready_q  <= '0;
                        m_start_q   <= 1'b1;
                        state_q     <= S_START;
                    end else begin
                        tx_ready_q <= ready_d;
                    end
                end
                S_START: begin
                    state_q <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (bus.m_done) begin
                        rx_data_q  <= bus.m_rx_data;
                        rx_valid_q <= grant_q;
                        cyc_cnt_q  <= '0;
                        if (byte_cnt_q == '0) begin
                            if (CS_HOLD_CYC == 0) begin
                                cs_n_q       <= '1;
                                grant_q      <= '0;
                                burst_done_q <= grant_q;
                                state_q      <= S_IDLE;
                            end else begin
                                state_q <= S_CS_HOLD;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q - 1'b1;
                            if (GAP_CYC == 0) begin
                                tx_ready_q <= ready_d;
                                state_q    <= S_WAIT_TX;
                            end else begin
                                state_q <= S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (cyc_cnt_q == CNT_W'(GAP_CYC - 1)) begin
                        tx_ready_q <= ready_d;
                        state_q    <= S_WAIT_TX;
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 1'b1;
                    end
                end
                S_CS_HOLD: begin
                    if (cyc_cnt_q == CNT_W'(CS_HOLD_CYC - 1)) begin
                        cs_n_q       <= '1;
                        grant_q      <= '0;
                        burst_done_q <= grant_q;
                        state_q      <= S_IDLE;
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.tx_ready   = tx_ready_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.burst_done = burst_done_q;
    assign bus.cs_n       = cs_n_q;
    assign bus.m_start    = m_start_q;
    assign bus.m_tx_data  = m_tx_data_q;

endmodule

// File: tb/tb_spi_burst_arbiter.sv
// Directed testbench for spi_burst_arbiter with a behavioural SPI master model.
module tb_spi_burst_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int LEN_W     = 4;
    localparam int GAP_CYC   = 1;
    localparam int SLAVE_CYC = 4;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    spi_burst_arbiter_if #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W)) bus ();

    spi_burst_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .LEN_W        (LEN_W),
        .CS_SETUP_CYC (2),
        .CS_HOLD_CYC  (2),
        .GAP_CYC      (GAP_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- monitor state ----------------
    int          cyc = 0;
    int          last_done = -1;
    int          first_start = -1;
    int          rx_cyc = -1;
    int          cs_fall = -1;
    int          cs_rise = -1;
    int          cs_fall_n = 0;
    int          cs_rise_n = 0;
    int          bd_cnt [NUM_REQ];
    logic [7:0]  start_log [$];
    logic [15:0] rx_log [$];
    logic [NUM_REQ-1:0] prev_csn;
    logic [NUM_REQ-1:0] prev_ready;

    logic [7:0]  tx_bytes [NUM_REQ][16];
    logic [7:0]  slave_xor;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural spi_master: busy for SLAVE_CYC cycles after m_start, then a
    // one-cycle m_done with rx = tx ^ slave_xor. Deliberately ignores rst so a
    // late m_done can arrive while the arbiter is idle.
    initial begin
        int         cnt;
        logic [7:0] latched;
        cnt = 0;
        latched = '0;
        bus.m_busy = 1'b0;
        bus.m_done = 1'b0;
        bus.m_rx_data = '0;
        forever begin
            @(posedge clk); #1;
            bus.m_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.m_busy = 1'b0;
                    bus.m_done = 1'b1;
                    bus.m_rx_data = latched ^ slave_xor;
                end
            end else if (bus.m_start === 1'b1) begin
                bus.m_busy = 1'b1;
                latched = bus.m_tx_data;
                cnt = SLAVE_CYC;
            end
        end
    end

    // Event logger plus per-cycle invariants.
    initial begin
        prev_csn = '1;
        prev_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) bd_cnt[i] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                checks++;
                assert ($countones(~bus.cs_n) <= 1) else begin
                    errors++;
                    $error("FAIL cs_overlap: observed cs_n=%b expected at most one low", bus.cs_n);
                end
                checks++;
                assert ($onehot0(bus.grant)) else begin
                    errors++;
                    $error("FAIL grant_onehot: observed grant=%b expected one-hot or zero", bus.grant);
                end
                if (bus.m_done) last_done = cyc;
                if (bus.m_start) begin
                    start_log.push_back(bus.m_tx_data);
                    if (first_start < 0) first_start = cyc;
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (bus.rx_valid[i]) begin
                        rx_log.push_back({8'(i), bus.rx_data});
                        rx_cyc = cyc;
                    end
                    if (bus.burst_done[i]) bd_cnt[i]++;
                end
                if ((~bus.cs_n) != '0 && (~prev_csn) == '0) begin
                    cs_fall = cyc;
                    cs_fall_n++;
                end
                if ((~bus.cs_n) == '0 && (~prev_csn) != '0) begin
                    cs_rise = cyc;
                    cs_rise_n++;
                end
                // Within a burst: m_done cycle, GAP_CYC idle cycles, then tx_ready.
                if (bus.tx_ready != '0 && prev_ready == '0 && last_done > cs_fall) begin
                    checks++;
                    assert (cyc - last_done - 1 == GAP_CYC) else begin
                        errors++;
                        $error("FAIL gap: observed %0d idle cycles expected %0d", cyc - last_done - 1, GAP_CYC);
                    end
                end
            end
            prev_csn = bus.cs_n;
            prev_ready = bus.tx_ready;
        end
    end

    // Serve one burst for whichever client is granted. Optionally stall before
    // byte stall_byte for stall_len cycles, and optionally drop req after grant.
    task automatic serve(input int stall_byte, input int stall_len, input bit drop_req,
                         output int who, output int nbytes);
        int cyc_w;
        bit stalled;
        cyc_w = 0;
        who = 0;
        nbytes = 0;
        stalled = 0;
        while (bus.grant == '0 && cyc_w < 100) begin
            @(posedge clk); #1;
            cyc_w++;
        end
        checks++;
        assert (bus.grant != '0) else begin
            errors++;
            $error("FAIL grant_timeout: observed grant=%b expected nonzero within 100 cycles", bus.grant);
        end
        if (bus.grant == '0) return;
        for (int i = 0; i < NUM_REQ; i++) if (bus.grant[i]) who = i;
        if (drop_req) bus.req[who] = 1'b0;
        cyc_w = 0;
        while (cyc_w < 400) begin
            if (bus.burst_done[who]) break;
            if (bus.tx_ready[who]) begin
                if (nbytes == stall_byte && !stalled) begin
                    stalled = 1;
                    for (int s = 0; s < stall_len; s++) begin
                        @(posedge clk); #1;
                        cyc_w++;
                        chk("stall_tx_ready", 32'(bus.tx_ready[who]), 32'd1);
                        chk("stall_cs_n", 32'(bus.cs_n[who]), 32'd0);
                        chk("stall_m_start", 32'(bus.m_start), 32'd0);
                    end
                end
                bus.tx_valid[who] = 1'b1;
                bus.tx_data[who*8 +: 8] = tx_bytes[who][nbytes];
                nbytes++;
                @(posedge clk); #1;
                bus.tx_valid = '0;
                cyc_w++;
            end else begin
                @(posedge clk); #1;
                cyc_w++;
            end
        end
        checks++;
        assert (cyc_w < 400) else begin
            errors++;
            $error("FAIL burst_timeout: observed %0d cycles expected burst_done before 400", cyc_w);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int who, nb, w, bd0, fall0, rise0, rxn0;
        for (int c = 0; c < NUM_REQ; c++)
            for (int k = 0; k < 16; k++)
                tx_bytes[c][k] = 8'((c << 4) | k);
        slave_xor = 8'h99;
        bus.req = '0;
        bus.req_len = '0;
        bus.tx_valid = '0;
        bus.tx_data = '0;

        // Reset state
        do_reset();
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_cs_n", 32'(bus.cs_n), 32'hF);
        chk("rst_tx_ready", 32'(bus.tx_ready), 32'h0);
        chk("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
        chk("rst_rx_data", 32'(bus.rx_data), 32'h0);
        chk("rst_burst_done", 32'(bus.burst_done), 32'h0);
        chk("rst_m_start", 32'(bus.m_start), 32'h0);
        chk("rst_m_tx_data", 32'(bus.m_tx_data), 32'h0);

        // Test 1: client 0, one byte 0xA5, slave returns 0x3C (0xA5 ^ 0x99)
        tx_bytes[0][0] = 8'hA5;
        first_start = -1;
        start_log.delete();
        rx_log.delete();
        bus.req = 4'b0001;
        serve(-1, 0, 1'b0, who, nb);
        bus.req = '0;
        settle(3);
        chk("t1_who", 32'(who), 32'd0);
        chk("t1_nbytes", 32'(nb), 32'd1);
        chk("t1_starts", 32'(start_log.size()), 32'd1);
        if (start_log.size() > 0) chk("t1_m_tx_data", 32'(start_log[0]), 32'hA5);
        chk("t1_rx_count", 32'(rx_log.size()), 32'd1);
        if (rx_log.size() > 0) chk("t1_rx", 32'(rx_log[0]), 32'h003C);
        chk("t1_burst_done", 32'(bd_cnt[0]), 32'd1);
        // 2 setup cycles + 1 WAIT_TX cycle (client answers at once) before START
        chk("t1_setup", 32'(first_start - cs_fall), 32'd3);
        // m_done cycle, 2 hold cycles, then cs_n high
        chk("t1_hold", 32'(cs_rise - last_done), 32'd3);
        chk("t1_rx_latency", 32'(rx_cyc - last_done), 32'd1);

        // Test 2: client 1, 4 bytes 0x01..0x04, slave returns ~tx
        slave_xor = 8'hFF;
        for (int k = 0; k < 4; k++) tx_bytes[1][k] = 8'(k + 1);
        start_log.delete();
        rx_log.delete();
        fall0 = cs_fall_n;
        rise0 = cs_rise_n;
        bus.req_len = 16'h0030;
        bus.req = 4'b0010;
        serve(-1, 0, 1'b0, who, nb);
        bus.req = '0;
        settle(3);
        chk("t2_who", 32'(who), 32'd1);
        chk("t2_nbytes", 32'(nb), 32'd4);
        chk("t2_starts", 32'(start_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < start_log.size(); k++)
            chk("t2_m_tx_data", 32'(start_log[k]), 32'(k + 1));
        chk("t2_rx_count", 32'(rx_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < rx_log.size(); k++)
            chk("t2_rx", 32'(rx_log[k]), 32'({8'd1, ~8'(k + 1)}));
        chk("t2_cs_falls", 32'(cs_fall_n - fall0), 32'd1);
        chk("t2_cs_rises", 32'(cs_rise_n - rise0), 32'd1);
        chk("t2_burst_done", 32'(bd_cnt[1]), 32'd1);

        // Test 3: all clients from reset, one byte each, reqs held high
        do_reset();
        bus.req_len = '0;
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            serve(-1, 0, 1'b0, who, nb);
            chk("t3_order", 32'(who), 32'(n % 4));
        end
        bus.req = '0;
        settle(4);
        chk("t3_idle_grant", 32'(bus.grant), 32'h0);

        // Test 4: client 2, 3 bytes, 50-cycle stall before the second byte
        bd0 = bd_cnt[2];
        start_log.delete();
        bus.req_len = 16'h0200;
        bus.req = 4'b0100;
        serve(1, 50, 1'b0, who, nb);
        bus.req = '0;
        settle(3);
        chk("t4_who", 32'(who), 32'd2);
        chk("t4_nbytes", 32'(nb), 32'd3);
        chk("t4_starts", 32'(start_log.size()), 32'd3);
        chk("t4_burst_done", 32'(bd_cnt[2] - bd0), 32'd1);

        // Test 5: reset during WAIT_DONE of a 3-byte burst on client 1
        bd0 = bd_cnt[1];
        start_log.delete();
        bus.req_len = 16'h0020;
        bus.req = 4'b0010;
        w = 0;
        while (bus.grant == '0 && w < 50) begin @(posedge clk); #1; w++; end
        chk("t5_grant", 32'(bus.grant), 32'h2);
        w = 0;
        while (!bus.tx_ready[1] && w < 50) begin @(posedge clk); #1; w++; end
        chk("t5_tx_ready", 32'(bus.tx_ready[1]), 32'd1);
        bus.tx_valid[1] = 1'b1;
        bus.tx_data[15:8] = 8'h55;
        @(posedge clk); #1;
        bus.tx_valid = '0;
        @(posedge clk); #1;
        chk("t5_started", 32'(start_log.size()), 32'd1);
        rxn0 = rx_log.size();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req = '0;
        chk("t5_cs_n", 32'(bus.cs_n), 32'hF);
        chk("t5_grant_clr", 32'(bus.grant), 32'h0);
        chk("t5_tx_ready_clr", 32'(bus.tx_ready), 32'h0);
        chk("t5_burst_done", 32'(bus.burst_done), 32'h0);
        settle(10);
        chk("t5_no_burst_done", 32'(bd_cnt[1] - bd0), 32'd0);
        chk("t5_no_rx", 32'(rx_log.size() - rxn0), 32'd0);
        chk("t5_still_idle", 32'(bus.grant), 32'h0);
        bus.req_len = '0;
        bus.req = 4'b1001;
        serve(-1, 0, 1'b0, who, nb);
        bus.req[0] = 1'b0;
        chk("t5_first_after_rst", 32'(who), 32'd0);
        serve(-1, 0, 1'b0, who, nb);
        bus.req[3] = 1'b0;
        chk("t5_second_after_rst", 32'(who), 32'd3);

        // Test 6: client 3, 2 bytes, req dropped right after grant
        settle(3);
        bd0 = bd_cnt[3];
        bus.req_len = 16'h1000;
        bus.req = 4'b1000;
        serve(-1, 0, 1'b1, who, nb);
        bus.req_len = 16'h0000;
        settle(10);
        chk("t6_who", 32'(who), 32'd3);
        chk("t6_nbytes", 32'(nb), 32'd2);
        chk("t6_burst_done", 32'(bd_cnt[3] - bd0), 32'd1);
        chk("t6_idle_grant", 32'(bus.grant), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
